// File: rtl/sim_mem_arb.sv
// Round-robin arbiter/sequencer giving two requesters shared access to one simulated memory.
// Latency: grant on the edge that samples req; one ACCESS cycle, then a one-cycle ack (3 cycles per transaction).
// Backpressure: a requester holds req and its operands until it sees ack; the losing requester simply waits.
//
// Ports:
//   clk, reset                        clock and asynchronous active-high reset
//   reqX/weX/addrX/dinX (X = A, B)    requester transaction inputs; weX == 0 means a read
//   ackX/doutX                        one-cycle completion pulse and the last read data for that requester
//   memAddr/memDin/memOe/memWea       memory pins driven by this block
//   memDout                           combinational read data from the memory, valid while memOe is high
//
// WIDTH must be a multiple of NBYTES; each write lane covers WIDTH/NBYTES bits.

module sim_mem_arb #(
  parameter int SIZE   = 4096,
  parameter int WIDTH  = 36,
  parameter int NBYTES = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    reqA,
  input  logic [NBYTES-1:0]       weA,
  input  logic [$clog2(SIZE)-1:0] addrA,
  input  logic [WIDTH-1:0]        dinA,
  output logic                    ackA,
  output logic [WIDTH-1:0]        doutA,
  input  logic                    reqB,
  input  logic [NBYTES-1:0]       weB,
  input  logic [$clog2(SIZE)-1:0] addrB,
  input  logic [WIDTH-1:0]        dinB,
  output logic                    ackB,
  output logic [WIDTH-1:0]        doutB,
  output logic [$clog2(SIZE)-1:0] memAddr,
  output logic [WIDTH-1:0]        memDin,
  input  logic [WIDTH-1:0]        memDout,
  output logic                    memOe,
  output logic [NBYTES-1:0]       memWea
);

  localparam int AW = $clog2(SIZE);

  typedef enum logic [1:0] {IDLE, ACCESS, ACK} state_t;

  state_t state;
  logic   owner;       // 0 = A, 1 = B: who the current transaction belongs to
  logic   last_grant;  // 0 = A, 1 = B: most recent winner, loses the next tie

  // Arbitration: a lone requester wins outright; on a tie the one that did
  // not win last time goes first.
  logic              pick_b;
  logic [AW-1:0]     sel_addr;
  logic [WIDTH-1:0]  sel_din;
  logic [NBYTES-1:0] sel_we;

  always_comb begin
    pick_b   = reqB && (!reqA || !last_grant);
    sel_addr = pick_b ? addrB : addrA;
    sel_din  = pick_b ? dinB  : dinA;
    sel_we   = pick_b ? weB   : weA;
  end

  // memAddr/memDin double as the latched transaction operands, so they keep
  // their last values while idle. memWea doubles as the latched write enables
  // and is cleared once ACCESS ends; memOe marks a read for the whole ACCESS
  // cycle. Because both are reset asynchronously, a reset during ACCESS
  // removes the write strobe before the committing edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      owner      <= 1'b0;
      last_grant <= 1'b1;
      memAddr    <= '0;
      memDin     <= '0;
      memOe      <= 1'b0;
      memWea     <= '0;
      ackA       <= 1'b0;
      ackB       <= 1'b0;
      doutA      <= '0;
      doutB      <= '0;
    end else begin
      case (state)
        IDLE: begin
          ackA <= 1'b0;
          ackB <= 1'b0;
          if (reqA || reqB) begin
            owner      <= pick_b;
            last_grant <= pick_b;
            memAddr    <= sel_addr;
            memDin     <= sel_din;
            memWea     <= sel_we;
            memOe      <= (sel_we == '0);
            state      <= ACCESS;
          end
        end
        ACCESS: begin
          memWea <= '0;
          memOe  <= 1'b0;
          // Read data is captured only into the owner's register; the other
          // requester's last read result is left untouched.
          if (memOe) begin
            if (owner) doutB <= memDout;
            else       doutA <= memDout;
          end
          ackA  <= !owner;
          ackB  <= owner;
          state <= ACK;
        end
        ACK: begin
          ackA  <= 1'b0;
          ackB  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          ackA  <= 1'b0;
          ackB  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/sim_mem_arb.md
Name: sim_mem_arb

Overview:
Two-requester arbiter and sequencer in front of the testbench simulated memory (36-bit words, byte-lane write enables, combinational read gated by oe). It owns the memory address, data-in, oe and wea pins. It grants one requester at a time with round-robin priority, and drives exactly one access cycle per transaction. It returns read data and a one-cycle ack to the winning requester. Typical use: the CPU-side model and the DMA/front-end model share one backing store.

Parameters:
SIZE, 4096, memory depth in words; the address width is $clog2(SIZE).
WIDTH, 36, word width in bits.
NBYTES, 4, number of write byte lanes; WIDTH % NBYTES must be 0, so lanes are 9 bits each by default.

Ports:
clk  in  1  clock; all state changes on the rising edge.
reset  in  1  asynchronous, active-high reset.
reqA  in  1  requester A transaction request (level).
weA  in  NBYTES  requester A lane write enables; all zero means a read.
addrA  in  $clog2(SIZE)  requester A word address.
dinA  in  WIDTH  requester A write data.
ackA  out  1  one-cycle completion pulse to A.
doutA  out  WIDTH  read data for A.
reqB, weB, addrB, dinB, ackB, doutB  same as A, for requester B.
memAddr  out  $clog2(SIZE)  to memory addr.
memDin  out  WIDTH  to memory din.
memDout  in  WIDTH  from memory dout.
memOe  out  1  to memory oe.
memWea  out  NBYTES  to memory wea.

Behaviour:
- Reset (async, immediate) sets the following:
  - state to IDLE and lastGrant to B, so A wins the first tie.
  - ackA, ackB and memOe to 0; memWea to all zeros.
  - memAddr, memDin, doutA and doutB to 0.
- FSM states: IDLE, ACCESS, ACK.
- IDLE:
  - With no request, stay in IDLE. All mem outputs are inactive: memWea is 0, memOe is 0, and memAddr/memDin hold their last values.
  - With exactly one request, grant that requester.
  - With both requesting, grant the requester that is not lastGrant.
  - On the grant edge: latch the winner's addr, din and we into internal registers, record the owner, update lastGrant, and go to ACCESS.
- ACCESS (exactly 1 cycle):
  - memAddr and memDin show the latched values.
  - For a write (latched we nonzero): memWea equals the latched we and memOe is 0. Memory commits the enabled lanes on the edge that ends ACCESS. Lanes whose enable is 0 are unchanged.
  - For a read: memWea is 0 and memOe is 1. On the ending edge, memDout is captured into the owner's dout register.
  - The other requester's dout is never disturbed.
  - Next state is ACK.
- ACK (exactly 1 cycle):
  - The owner's ack is 1; the other ack is 0. memWea is 0 and memOe is 0.
  - Next state is IDLE.
- Handshake:
  - The requester holds req and its addr/din/we stable until it sees ack.
  - It deasserts req on the edge that samples ack high.
  - A req still high in IDLE after an ACK is treated as a new transaction.
  - A non-owner's inputs are ignored until it is granted, and its req may stay high across the other requester's whole transaction.
- Latency and throughput:
  - req is sampled high in IDLE at edge t0. ACCESS occupies the cycle after t0, and ack is high in the cycle after that.
  - For a read, dout is valid when ack is high, and it holds until that requester's next read completes.
  - Maximum throughput is one transaction per 3 cycles. With back-to-back contention the grants alternate A, B, A, B.
- Writes on a read: a write transaction leaves the owner's dout unchanged.
- Reset mid-operation: if reset asserts during ACCESS before the rising edge, memWea drops to 0 combinationally, so no write occurs. The pending ack is lost, and the requester must retry.
- Inputs that change while the block is in ACCESS or ACK have no effect, because the latched copies are used.
- Invariants: memWea is nonzero only in ACCESS, memOe is 1 only in ACCESS during a read, and ackA and ackB are never 1 together.

Test Plan:
1. Assert reset mid-run, then release it → all outputs are 0 and the state is IDLE. Then raise reqA and reqB together → A is granted first, with ackA at cycle t0+2 and ackB at t0+5.
2. A writes addr 0o17 with data 36'o123456701234 and weA=4'b1111, then A reads 0o17 → the write is acked at t0+2, and at the read ack doutA = 36'o123456701234 with memOe having been high for exactly 1 cycle.
3. A pre-fills addr 5 with 36'o777777777777, then B writes data 0 to addr 5 with weB=4'b0100, then B reads addr 5 → doutB = 36'o777000777777 (only lane 2 cleared), and doutA is unchanged.
4. reqA and reqB are both held continuously for 6 transactions → the grant order is A,B,A,B,A,B, acks are spaced 3 cycles apart, and ackA and ackB never overlap.
5. Assert reset during the ACCESS cycle of a write of data 1 to addr 3, where addr 3 was previously 0 → memWea drops to 0 immediately, no ack is issued, and a subsequent read of addr 3 returns 0.
6. B changes addrB and dinB while A's transaction is in ACCESS, and B's req stays high → B's transaction uses the values present at B's grant edge, with no corruption of A's access.
